// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_if
// Purpose  : Control/status bundle between the multi-cycle MIPS controller
//            and its datapath + shared memory port.
// Revision : 1.0
// ============================================================================
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       signext;
    logic       shiftl16;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, alucontrol, pcsrc, signext, shiftl16,
               illegal, bus_err, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, alucontrol, pcsrc, signext, shiftl16,
               illegal, bus_err, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : State sequencer for a shared-memory multi-cycle MIPS datapath,
//            with ready-gated memory states and a bounded wait timeout.
// Revision : 1.0
// ============================================================================
module multicycle_controller #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  wire logic                clk,
    input  wire logic                reset,
    multicycle_controller_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12
    } state_e;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_fn_jr    = 6'b001000;

    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               limit_hit;
    logic               rtype_ok;

    // A zero limit removes the timeout path entirely.
    generate
        if (WAIT_LIMIT != 0) begin : g_timeout
            assign limit_hit = (wcnt_q == CNT_W'(WAIT_LIMIT - 1));
        end else begin : g_no_timeout
            assign limit_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        case (bus.funct)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b101010, 6'b101011: rtype_ok = 1'b1;
            default:                                    rtype_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        wcnt_d          = '0;
        bus.pcen        = 1'b0;
        bus.iord        = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.regwrite    = 1'b0;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.alucontrol  = c_alu_add;
        bus.pcsrc       = 2'b00;
        bus.signext     = 1'b0;
        bus.shiftl16    = 1'b0;
        bus.illegal     = 1'b0;
        bus.bus_err     = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                if (bus.mem_ready) begin
                    bus.irwrite = 1'b1;
                    bus.pcen    = 1'b1;
                    state_d     = S_DECODE;
                end else if (limit_hit) begin
                    bus.bus_err = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                bus.signext = 1'b1;
                case (bus.op)
                    c_op_lw, c_op_sw: state_d = S_MEMADR;
                    c_op_rtype: begin
                        if (bus.funct == c_fn_jr) begin
                            state_d = S_JR;
                        end else if (rtype_ok) begin
                            state_d = S_RTEX;
                        end else begin
                            bus.illegal = 1'b1;
                            state_d     = S_FETCH;
                        end
                    end
                    c_op_beq, c_op_bne:                       state_d = S_BRANCH;
                    c_op_addi, c_op_addiu, c_op_ori, c_op_lui: state_d = S_IEX;
                    c_op_j:                                   state_d = S_JUMP;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.signext = 1'b1;
                state_d     = (bus.op == c_op_sw) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (limit_hit) begin
                    bus.bus_err = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (limit_hit) begin
                    bus.memwrite = 1'b0;
                    bus.bus_err  = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RTEX: begin
                bus.alusrca = 1'b1;
                case (bus.funct)
                    6'b100010, 6'b100011: bus.alucontrol = c_alu_sub;
                    6'b100100:            bus.alucontrol = c_alu_and;
                    6'b100101:            bus.alucontrol = c_alu_or;
                    6'b101010, 6'b101011: bus.alucontrol = c_alu_slt;
                    default:              bus.alucontrol = c_alu_add;
                endcase
                state_d = S_RTWB;
            end
            S_RTWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = c_alu_sub;
                bus.pcsrc      = 2'b01;
                bus.pcen       = (bus.op == c_op_bne) ? ~bus.zero : bus.zero;
                state_d        = S_FETCH;
            end
            S_IEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                case (bus.op)
                    c_op_addi, c_op_addiu: bus.signext = 1'b1;
                    c_op_ori:              bus.alucontrol = c_alu_or;
                    c_op_lui:              bus.shiftl16 = 1'b1;
                    default:               bus.signext = 1'b0;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                bus.pcen  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JR: begin
                bus.pcsrc = 2'b11;
                bus.pcen  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every architectural side effect in the abort cycle.
        if (reset) begin
            bus.pcen     = 1'b0;
            bus.irwrite  = 1'b0;
            bus.regwrite = 1'b0;
            bus.memwrite = 1'b0;
            bus.illegal  = 1'b0;
            bus.bus_err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.state = state_q;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM controller that sequences a shared-memory, multi-cycle build of the MIPS datapath.
- One unified memory port serves both instruction fetch and data access.
- Internal registers IR, A, B, ALUOut and Data live in the datapath; this block generates every enable and mux select per cycle.
- Memory accesses are gated by a ready handshake with a bounded wait timeout.

Parameters:
- WAIT_LIMIT, 16: max cycles a memory state waits for mem_ready before abort; 0 = wait forever.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcen  out  1  PC register write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- regwrite  out  1  register file write enable
- regdst  out  1  write register select: 1 = rd, 0 = rt
- memtoreg  out  1  writeback select: 1 = Data, 0 = ALUOut
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsrc  out  2  PC source: 00 ALUResult, 01 ALUOut, 10 jump target, 11 A (jr)
- signext  out  1  1 = sign-extend immediate, 0 = zero-extend
- shiftl16  out  1  immediate << 16 (lui)
- illegal  out  1  1-cycle pulse: unsupported opcode or funct
- bus_err  out  1  1-cycle pulse: memory wait timeout
- state  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, IEX=9, IWB=10, JUMP=11, JR=12. Codes 13–15 go to FETCH on the next edge.
- Reset: a reset edge sets state=FETCH and wcnt=0. While reset is high, pcen, irwrite, regwrite, memwrite, illegal and bus_err are forced 0. Any state, including a memory wait, aborts to FETCH.
- Outputs are a function of state (plus mem_ready, zero, op, funct). Any output not listed for a state is 0; alucontrol defaults to 010.
- FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00.
  - mem_ready=1: irwrite=1, pcen=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alusrca=0, alusrcb=11, signext=1 (ALUOut = branch target). Next state:
  - lw (100011) or sw (101011) -> MEMADR
  - op=000000 with funct=001000 -> JR
  - op=000000 with funct in {100000, 100001, 100010, 100011, 100100, 100101, 101010, 101011} -> RTEX
  - beq (000100) or bne (000101) -> BRANCH
  - addi (001000), addiu (001001), ori (001101), lui (001111) -> IEX
  - j (000010) -> JUMP
  - Anything else: illegal=1, go to FETCH (instruction is a no-op; PC already advanced).
- MEMADR: alusrca=1, alusrcb=10, signext=1. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. mem_ready=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1 held until the mem_ready cycle (inclusive), then FETCH.
- RTEX: alusrca=1, alusrcb=00, alucontrol decoded from funct, then RTWB.
- RTWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01. pcen = zero for beq, ~zero for bne. Then FETCH.
- IEX: alusrca=1, alusrcb=10.
  - addi/addiu: signext=1, add.
  - ori: signext=0, or.
  - lui: signext=0, shiftl16=1, add.
  - Then IWB.
- IWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JUMP: pcsrc=10, pcen=1, then FETCH.
- JR: pcsrc=11, pcen=1, then FETCH.
- Wait counter (wcnt):
  - Clears on entry to FETCH, MEMRD or MEMWR and whenever mem_ready=1.
  - Increments on each cycle in those states with mem_ready=0.
  - If WAIT_LIMIT≠0 and wcnt==WAIT_LIMIT-1 with mem_ready=0: bus_err=1, memwrite=0, irwrite=0, pcen=0 that cycle, go to FETCH.
  - A FETCH timeout re-fetches the same PC.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- Latency with mem_ready held at 1 (cycles from FETCH entry to next FETCH entry):
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - branch: 3
  - j: 3
  - jr: 3
  - Each memory state adds one cycle per mem_ready=0 cycle.

Test Plan:
- Reset, then lw (op=100011) with mem_ready low 2 cycles in FETCH and MEMRD each -> state sequence 0,0,0,1,2,3,3,3,4,0; exactly one irwrite, one regwrite (memtoreg=1).
- sw with mem_ready=1 -> memwrite=1 for exactly 1 cycle in MEMWR with iord=1; regwrite never asserted.
- beq with zero=1, then bne with zero=1 -> pcen=1 in BRANCH for beq, pcen=0 for bne; pcsrc=01 and alucontrol=110 in both.
- op=000000, funct=001000 -> JR in 3 cycles with pcsrc=11, pcen=1; op=111111 -> illegal pulse in DECODE, return to FETCH, regwrite never 1.
- WAIT_LIMIT=4, mem_ready stuck 0 in MEMWR -> memwrite high 3 cycles, bus_err pulse on 4th with memwrite=0, next state FETCH.
- Reset asserted in MEMRD wait; lui in IEX -> reset: next state FETCH, no regwrite. lui: shiftl16=1, signext=0, alusrcb=10, alucontrol=010.
